// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and BCD helpers for the countdown timer front-end.
package timer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSED, EXPIRED} state_e;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int MAX_DIGITS = 8;
  localparam int VEC_W = 4 * MAX_DIGITS;
  function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction
  // Full-width compare: a non-BCD nibble still reads as nonzero.
  function automatic logic bcd_all_zero(input logic [VEC_W-1:0] v);
    return v == '0;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the terminal count.
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] count_q, count_d;
  assign tick_o = enable_i && count_q == LAST;
  always_comb count_d = clr_i ? '0 : !enable_i ? count_q : tick_o ? '0 : count_q + W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: command arbitration, state machine and strobe generation for a BCD countdown chain.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] load_value_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    clear_i,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd_i,
  output logic                    reconfig_o,
  output logic [4*NUM_DIGITS-1:0] set_digits_o,
  output logic                    decrement_o,
  output logic                    reset_timer_o,
  output logic                    running_o,
  output logic                    expired_o,
  output logic                    expired_pulse_o
);
  localparam int DW = 4 * NUM_DIGITS;
  state_e state_q, state_d;
  logic [DW-1:0] set_clamped, set_digits_q, set_digits_d;
  logic reconfig_q, reconfig_d, decrement_q, decrement_d, reset_timer_q, reset_timer_d;
  logic running_q, running_d, expired_q, expired_d, expired_pulse_q, expired_pulse_d;
  logic zero, cmd_load, cmd_stop, cmd_start, load_ok, tick;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_clamp
    assign set_clamped[4*g +: 4] = bcd_clamp(load_value_i[4*g +: 4]);
  end
  assign zero      = bcd_all_zero(VEC_W'(digits_bcd_i));
  assign cmd_load  = load_i && !clear_i;
  assign cmd_stop  = stop_i && !clear_i && !load_i;
  assign cmd_start = start_i && !clear_i && !load_i && !stop_i;
  assign load_ok   = cmd_load && state_q inside {IDLE, PAUSED, EXPIRED};
  // Counting pauses on zero so the terminal count is never spent on a suppressed decrement.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (state_q == RUN && !zero && !clear_i),
    .clr_i    (clear_i || state_q == LOAD),
    .tick_o   (tick)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:         state_d = IDLE;
      IDLE, PAUSED: state_d = (cmd_start && !zero) ? RUN : state_q;
      RUN:          state_d = cmd_stop ? PAUSED : zero ? EXPIRED : RUN;
      default:      state_d = state_q;
    endcase
    if (load_ok) state_d = LOAD;
    if (clear_i) state_d = IDLE;
  end
  always_comb begin
    reconfig_d      = state_d == LOAD;
    set_digits_d    = clear_i ? '0 : load_ok ? set_clamped : set_digits_q;
    decrement_d     = tick;
    reset_timer_d   = clear_i;
    running_d       = state_d == RUN;
    expired_d       = state_d == EXPIRED;
    expired_pulse_d = state_d == EXPIRED && state_q != EXPIRED;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q         <= IDLE;
      set_digits_q    <= '0;
      reconfig_q      <= 1'b0;
      decrement_q     <= 1'b0;
      reset_timer_q   <= 1'b0;
      running_q       <= 1'b0;
      expired_q       <= 1'b0;
      expired_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      set_digits_q    <= set_digits_d;
      reconfig_q      <= reconfig_d;
      decrement_q     <= decrement_d;
      reset_timer_q   <= reset_timer_d;
      running_q       <= running_d;
      expired_q       <= expired_d;
      expired_pulse_q <= expired_pulse_d;
    end
  assign reconfig_o      = reconfig_q;
  assign set_digits_o    = set_digits_q;
  assign decrement_o     = decrement_q;
  assign reset_timer_o   = reset_timer_q;
  assign running_o       = running_q;
  assign expired_o       = expired_q;
  assign expired_pulse_o = expired_pulse_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: vector table plus multi-cycle sequences against a modelled digit-slice chain.
module tb_timer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic load_i = 0, start_i = 0, stop_i = 0, clear_i = 0;
  logic [15:0] load_value_i = '0, dig_force = '0, slice = '0, digits_bcd;
  logic use_slice = 1'b0;
  logic reconfig_o, decrement_o, reset_timer_o, running_o, expired_o, expired_pulse_o;
  logic [15:0] set_digits_o;
  logic [21:0] outv;
  int total = 0, bad = 0;

  typedef struct {
    logic ld, st, sp, cl;
    logic [15:0] lv, dig;
    logic [21:0] exp;
  } vec_t;
  vec_t vt[$];
  logic [21:0] sb[$];
  int dec_sb[$];

  always #5 clk = ~clk;

  timer_ctrl #(.NUM_DIGITS(4), .TICK_DIV(10)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .load_value_i(load_value_i),
    .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i), .digits_bcd_i(digits_bcd),
    .reconfig_o(reconfig_o), .set_digits_o(set_digits_o), .decrement_o(decrement_o),
    .reset_timer_o(reset_timer_o), .running_o(running_o), .expired_o(expired_o),
    .expired_pulse_o(expired_pulse_o)
  );

  assign digits_bcd = use_slice ? slice : dig_force;
  assign outv = {reconfig_o, set_digits_o, decrement_o, reset_timer_o, running_o, expired_o, expired_pulse_o};

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] != 0) begin
        r[4*i +: 4] = r[4*i +: 4] - 4'd1;
        return r;
      end
      r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  always @(posedge clk)
    if (reset_timer_o) slice <= '0;
    else if (reconfig_o) slice <= set_digits_o;
    else if (decrement_o) slice <= bcd_dec(slice);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {load_i, start_i, stop_i, clear_i} = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic preset(input logic [15:0] v);
    use_slice = 1'b1;
    load_value_i = v;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    step();
  endtask

  task automatic add(input logic ld, st, sp, cl, input logic [15:0] lv, dig,
                     input logic rc, input logic [15:0] sd, input logic rt, run, ex, ep);
    vt.push_back('{ld, st, sp, cl, lv, dig, {rc, sd, 1'b0, rt, run, ex, ep}});
  endtask

  initial begin
    int c, first_dec, ep_cnt, ep_at, last_dec, dcnt;
    //  ld st sp cl  lv        dig        rc sd        rt run ex ep
    add(1, 0, 0, 0, 16'h0F25, 16'h0000, 1, 16'h0925, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0925, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0925, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0925, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0925, 0, 16'h0925, 0, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0925, 0, 16'h0925, 0, 1, 0, 0);
    add(0, 0, 1, 0, 16'h0000, 16'h0925, 0, 16'h0925, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0925, 0, 16'h0925, 0, 1, 0, 0);
    add(1, 0, 0, 0, 16'h1234, 16'h0925, 0, 16'h0925, 0, 1, 0, 0);
    add(0, 1, 1, 0, 16'h0000, 16'h0925, 0, 16'h0925, 0, 0, 0, 0);
    add(1, 0, 0, 0, 16'h9999, 16'h0925, 1, 16'h9999, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0925, 0, 16'h9999, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h9999, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h00A0, 0, 16'h9999, 0, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h9999, 0, 0, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h9999, 0, 0, 1, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h9999, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 16'h5A0F, 16'h0000, 1, 16'h5909, 0, 0, 0, 0);
    add(1, 1, 0, 1, 16'h1111, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 1, 0, 16'h0000, 16'h0925, 0, 16'h0000, 0, 0, 0, 0);

    do_reset();
    sb.push_back('0);
    chk("reset_state", 32'(outv), 32'(sb.pop_front()));
    foreach (vt[i]) begin
      {load_i, start_i, stop_i, clear_i} = {vt[i].ld, vt[i].st, vt[i].sp, vt[i].cl};
      load_value_i = vt[i].lv;
      dig_force = vt[i].dig;
      sb.push_back(vt[i].exp);
      step();
      chk($sformatf("vec%0d", i), 32'(outv), 32'(sb.pop_front()));
    end
    {load_i, start_i, stop_i, clear_i} = '0;

    // Pacing from 003 down to expiry.
    do_reset();
    preset(16'h0003);
    chk("pace_preset", 32'(slice), 32'h3);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("pace_running", 32'(running_o), 1);
    dec_sb = '{10, 20, 30};
    ep_cnt = 0; ep_at = 0; last_dec = 0;
    for (c = 1; c <= 60; c++) begin
      step();
      if (decrement_o) begin
        last_dec = c;
        if (dec_sb.size() == 0) chk("pace_extra_dec", 32'(c), 0);
        else chk("pace_dec_cycle", 32'(c), 32'(dec_sb.pop_front()));
      end
      if (expired_pulse_o) begin
        ep_cnt++;
        ep_at = c;
      end
    end
    chk("pace_dec_missing", 32'(dec_sb.size()), 0);
    chk("pace_ep_count", 32'(ep_cnt), 1);
    chk("pace_ep_cycle", 32'(ep_at), 32'(last_dec + 2));
    chk("pace_expired_lvl", 32'(expired_o), 1);
    chk("pace_digits", 32'(slice), 0);

    // Pause with stop presented at prescaler count 6.
    do_reset();
    preset(16'h0050);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    dcnt = 0;
    for (c = 1; c <= 6; c++) begin
      step();
      dcnt += int'(decrement_o);
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("pause_running", 32'(running_o), 0);
    for (c = 0; c < 20; c++) begin
      step();
      dcnt += int'(decrement_o);
    end
    chk("pause_no_dec", 32'(dcnt), 0);
    chk("pause_still", 32'(running_o), 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("resume_running", 32'(running_o), 1);
    first_dec = 0;
    for (c = 1; c <= 15; c++) begin
      step();
      if (decrement_o && first_dec == 0) first_dec = c;
    end
    chk("resume_first_dec", 32'(first_dec), 3);

    // clear+load+start in RUN exactly at the terminal prescaler count.
    do_reset();
    preset(16'h0005);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    dcnt = 0;
    for (c = 1; c <= 9; c++) begin
      step();
      dcnt += int'(decrement_o);
    end
    {clear_i, load_i, start_i} = 3'b111;
    load_value_i = 16'h0007;
    step();
    {clear_i, load_i, start_i} = 3'b000;
    chk("prio_vec", 32'(outv), 32'({1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    step();
    chk("prio_after", 32'(outv), 32'(0));
    for (c = 0; c < 12; c++) begin
      step();
      dcnt += int'(decrement_o);
    end
    chk("prio_no_dec", 32'(dcnt), 0);
    chk("prio_digits", 32'(slice), 0);

    // Asynchronous reset between edges in RUN.
    do_reset();
    preset(16'h0050);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    chk("areset_pre_run", 32'(running_o), 1);
    #3 rst_n = 1'b0;
    #1 chk("areset_outputs", 32'(outv), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    step();
    chk("areset_idle", 32'(outv), 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("areset_restart", 32'(running_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control front-end for a cascade of BCD countdown digit slices. It latches a preset, drives the slices' load, decrement and clear strobes, and paces decrements from a clock prescaler. It watches the digit values to detect expiry. It sits between the user/register interface and the digit chain, and is the only initiator of strobes into that chain.

## Interface
- NUM_DIGITS, 4, number of BCD digit slices controlled (1..8)
- TICK_DIV, 10, clk cycles per decrement tick (≥2)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load  in  1  pulse: capture load_value and reprogram digits
- load_value  in  4*NUM_DIGITS  BCD preset, digit 0 = LSD at [3:0]
- start  in  1  pulse: begin/resume countdown
- stop  in  1  pulse: pause countdown
- clear  in  1  pulse: zero all digits, return to IDLE
- digits_bcd  in  4*NUM_DIGITS  current digit values fed back from slices
- reconfig  out  1  one-cycle load strobe to all slices
- set_digits  out  4*NUM_DIGITS  per-digit preset, each nibble clamped to 9
- decrement  out  1  one-cycle decrement strobe to LSD slice
- reset_timer  out  1  one-cycle clear strobe to all slices
- running  out  1  high in RUN
- expired  out  1  level, high in EXPIRED
- expired_pulse  out  1  one-cycle pulse on entry to EXPIRED

## Operation
- States: IDLE, LOAD, RUN, PAUSED, EXPIRED. Reset → IDLE.
- Command priority per cycle: clear > load > stop > start. Lower-priority commands in the same cycle are dropped.
- clear, any state: reset_timer=1 next cycle, prescaler=0, state → IDLE, set_digits register=0.
- load, in IDLE/PAUSED/EXPIRED: latch clamp(load_value) into set_digits (nibble >9 → 9), → LOAD. load in RUN is ignored.
- LOAD: reconfig=1 for exactly one cycle. Prescaler cleared. Next state is IDLE.
- start in IDLE or PAUSED:
  - if digits_bcd is nonzero → RUN;
  - if all digits are zero, ignored, state unchanged.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At count TICK_DIV-1, decrement=1 for one cycle, unless digits_bcd is all zero.
  - When digits_bcd is all zero → EXPIRED and expired_pulse=1.
- stop in RUN → PAUSED. Prescaler value is held; resume continues from the held count. stop in other states is ignored.
- EXPIRED: no decrements. expired=1 until load or clear.
- Zero detection is the full-width compare digits_bcd == 0. A non-BCD feedback nibble counts as nonzero.

## Timing
- All outputs are registered. Reset values: reconfig=0, set_digits=0, decrement=0, reset_timer=0, running=0, expired=0, expired_pulse=0, prescaler=0.
- Command pulse at edge N → strobe/state visible after edge N+1 (1-cycle latency).
- The decrement issued at edge T is reflected in digits_bcd after edge T+1. Zero is seen in cycle T+1, and EXPIRED/expired_pulse are visible after edge T+2.
- The prescaler in RUN does not advance in the cycle decrement is suppressed by zero.
- Mid-operation reset: asynchronous return to reset values and IDLE. The latched preset is lost.
- A clear coincident with the terminal prescaler count wins: no decrement is issued.

## Structure
- Package timer_pkg holds:
  - state enum (IDLE, LOAD, RUN, PAUSED, EXPIRED);
  - constant BCD_MAX=4'd9;
  - function bcd_clamp(nibble);
  - function bcd_all_zero(vector).
- Sub-module tick_prescaler (params TICK_DIV; ports clk, reset, enable, clr, tick). Width is $clog2(TICK_DIV). tick is high in the cycle count==TICK_DIV-1 with enable.
- The top FSM, command arbitration and output registers live in timer_ctrl.

## Test plan
- Load: load_value=16'h0F25 with load → set_digits=16'h0925 and reconfig high exactly 1 cycle, then IDLE.
- Pacing: with digits_bcd=0003 (slice model attached), start; TICK_DIV=10 → decrement pulses exactly 10 cycles apart. Three pulses occur, then expired_pulse once; expired stays high; no further decrement.
- Pause: stop at prescaler=6, wait 20 cycles, start → next decrement 3 cycles after RUN resumes, with no decrement while PAUSED.
- Zero start: digits all zero, start → state stays IDLE, running=0, no strobes.
- Priority: clear+load+start in the same cycle in RUN → reset_timer for 1 cycle, IDLE, no reconfig, no decrement.
- Reset: assert reset asynchronously mid-RUN between edges → all outputs 0 immediately. After release, start is required to run again.
